// File: rtl/grf_scoreboard_pkg.sv
// Shared CPU constants: default GRF geometry and the hardwired zero-register index.
package grf_scoreboard_pkg;

  localparam int unsigned GRF_DW   = 32;  // data width
  localparam int unsigned GRF_NREG = 32;  // register count
  localparam int unsigned GRF_AW   = 5;   // log2(GRF_NREG)
  localparam int unsigned GRF_CW   = 2;   // pending-write counter width
  localparam int unsigned ZERO_IDX = 0;   // hardwired-zero register index

endpackage

// File: rtl/grf_scoreboard_if.sv
// GRF access bus: D-stage reads/issue and W-stage writeback/retire.
//   master: pipeline side (drives addresses, write data, issue/retire)
//   slave : register file (returns read data, busy bits, sticky errors)
interface grf_scoreboard_if
  import grf_scoreboard_pkg::*;
#(
  parameter int unsigned DW = GRF_DW,
  parameter int unsigned AW = GRF_AW,
  parameter int unsigned NR = 2,
  parameter int unsigned NW = 1
) ();

  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_retire;
  logic             issue_en;
  logic [AW-1:0]    issue_addr;
  logic             ovf_err;
  logic             unf_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_retire, issue_en, issue_addr,
    input  rd_data, rd_busy, ovf_err, unf_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_retire, issue_en, issue_addr,
    output rd_data, rd_busy, ovf_err, unf_err
  );

endinterface

// File: rtl/grf_sb_counter.sv
// Saturating up/down pending-write counter for one register.
//   clk, reset    : clock, synchronous active-high reset
//   inc           : one issue this cycle
//   dec           : number of retires this cycle
//   cnt           : registered count
//   ovf_pulse_c   : this cycle's update would exceed the max (combinational)
//   unf_pulse_c   : this cycle's update would go below zero (combinational)
module grf_sb_counter #(
  parameter int unsigned CW   = 2,
  parameter int unsigned DECW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic [DECW-1:0] dec,
  output logic [CW-1:0]   cnt,
  output logic            ovf_pulse_c,
  output logic            unf_pulse_c
);

  // One spare bit above the largest magnitude plus a sign bit.
  localparam int unsigned SW = CW + DECW + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [SW-1:0] sum_c;

  // Net change with clamping at both ends.
  always_comb begin
    sum_c       = $signed(SW'(cnt_q)) + $signed(SW'(inc)) - $signed(SW'(dec));
    cnt_d       = sum_c[CW-1:0];
    ovf_pulse_c = 1'b0;
    unf_pulse_c = 1'b0;
    if (sum_c[SW-1]) begin
      cnt_d       = '0;
      unf_pulse_c = 1'b1;
    end else if (sum_c > $signed(SW'(CNT_MAX))) begin
      cnt_d       = CNT_MAX;
      ovf_pulse_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/grf_scoreboard.sv
// Parametrised general register file with write-to-read bypass and a
// per-register pending-write scoreboard.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of grf_scoreboard_if (reads, writes, issue/retire,
//                busy bits, sticky ovf_err/unf_err)
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int unsigned DW       = GRF_DW,
  parameter int unsigned NREG     = GRF_NREG,
  parameter int unsigned AW       = GRF_AW,
  parameter int unsigned NR       = 2,
  parameter int unsigned NW       = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CW       = GRF_CW
) (
  input  logic            clk,
  input  logic            reset,
  grf_scoreboard_if.slave bus
);

  // Enough to count two retiring write ports.
  localparam int unsigned DECW = 2;

  logic [DW-1:0]   mem_q [NREG];
  logic [DW-1:0]   mem_d [NREG];
  logic [CW-1:0]   reg_cnt [NREG];
  logic [NREG-1:0] ovf_pulse_c;
  logic [NREG-1:0] unf_pulse_c;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  function automatic logic is_hz(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
  endfunction

  // Write-priority mux: later (higher-index) ports overwrite earlier ones.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NW; k++) begin
      if (bus.wr_en[k] && !is_hz(bus.wr_addr[k*AW +: AW]))
        mem_d[bus.wr_addr[k*AW +: AW]] = bus.wr_data[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports: storage, optionally overridden by same-cycle write data.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NR; i++) begin
      bus.rd_data[i*DW +: DW] = mem_q[bus.rd_addr[i*AW +: AW]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NW; k++) begin
          if (bus.wr_en[k] && (bus.wr_addr[k*AW +: AW] == bus.rd_addr[i*AW +: AW]))
            bus.rd_data[i*DW +: DW] = bus.wr_data[k*DW +: DW];
        end
      end
      if (is_hz(bus.rd_addr[i*AW +: AW])) bus.rd_data[i*DW +: DW] = '0;
      // Busy reflects registered counts only.
      bus.rd_busy[i] = (reg_cnt[bus.rd_addr[i*AW +: AW]] != '0);
    end
  end

  // One pending-write counter per register; the zero register never counts.
  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    logic            inc_c;
    logic [DECW-1:0] dec_c;

    always_comb begin
      inc_c = bus.issue_en && (bus.issue_addr == AW'(r));
      dec_c = '0;
      for (int k = 0; k < NW; k++) begin
        if (bus.wr_en[k] && bus.wr_retire[k] && (bus.wr_addr[k*AW +: AW] == AW'(r)))
          dec_c = dec_c + DECW'(1);
      end
      if (is_hz(AW'(r))) begin
        inc_c = 1'b0;
        dec_c = '0;
      end
    end

    grf_sb_counter #(
      .CW   (CW),
      .DECW (DECW)
    ) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .inc         (inc_c),
      .dec         (dec_c),
      .cnt         (reg_cnt[r]),
      .ovf_pulse_c (ovf_pulse_c[r]),
      .unf_pulse_c (unf_pulse_c[r])
    );
  end

  // Sticky error flags.
  always_comb begin
    ovf_d = ovf_q | (|ovf_pulse_c);
    unf_d = unf_q | (|unf_pulse_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench: two GRFs (bypass on / bypass off) share one stimulus
// stream; a reference model predicts every cycle's outputs into a queue that
// a separate monitor drains and compares.
module tb_grf_scoreboard;
  import grf_scoreboard_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned NR   = 4;
  localparam int unsigned NW   = 2;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_scoreboard_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus_a ();
  grf_scoreboard_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus_b ();

  assign bus_b.rd_addr    = bus_a.rd_addr;
  assign bus_b.wr_en      = bus_a.wr_en;
  assign bus_b.wr_addr    = bus_a.wr_addr;
  assign bus_b.wr_data    = bus_a.wr_data;
  assign bus_b.wr_retire  = bus_a.wr_retire;
  assign bus_b.issue_en   = bus_a.issue_en;
  assign bus_b.issue_addr = bus_a.issue_addr;

  grf_scoreboard #(
    .DW(DW), .NREG(NREG), .AW(AW), .NR(NR), .NW(NW),
    .BYPASS(1), .ZERO_REG(1), .CW(CW)
  ) u_dut_byp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  grf_scoreboard #(
    .DW(DW), .NREG(NREG), .AW(AW), .NR(NR), .NW(NW),
    .BYPASS(0), .ZERO_REG(1), .CW(CW)
  ) u_dut_nobyp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct packed {
    logic [NR*DW-1:0] a_data;
    logic [NR*DW-1:0] b_data;
    logic [NR-1:0]    busy;
    logic             ovf;
    logic             unf;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [DW-1:0] m_reg [NREG];
  int            m_cnt [NREG];
  logic          m_ovf, m_unf;

  // Current stimulus.
  logic          s_reset;
  logic [AW-1:0] s_rd [NR];
  logic          s_we [NW];
  logic [AW-1:0] s_wa [NW];
  logic [DW-1:0] s_wd [NW];
  logic          s_ret [NW];
  logic          s_iss;
  logic [AW-1:0] s_ia;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    logic [DW-1:0] v;
    v = m_reg[a];
    if (byp)
      for (int k = 0; k < NW; k++)
        if (s_we[k] && s_wa[k] == a) v = s_wd[k];
    if (a == '0) v = '0;
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r] = '0;
      m_cnt[r] = 0;
    end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic drive();
    reset            = s_reset;
    bus_a.issue_en   = s_iss;
    bus_a.issue_addr = s_ia;
    for (int i = 0; i < NR; i++) bus_a.rd_addr[i*AW +: AW] = s_rd[i];
    for (int k = 0; k < NW; k++) begin
      bus_a.wr_en[k]             = s_we[k];
      bus_a.wr_retire[k]         = s_ret[k];
      bus_a.wr_addr[k*AW +: AW]  = s_wa[k];
      bus_a.wr_data[k*DW +: DW]  = s_wd[k];
    end
  endtask

  task automatic idle();
    s_reset = 1'b0;
    s_iss   = 1'b0;
    s_ia    = '0;
    for (int k = 0; k < NW; k++) begin
      s_we[k]  = 1'b0;
      s_ret[k] = 1'b0;
      s_wa[k]  = '0;
      s_wd[k]  = '0;
    end
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    s_rd[0] = AW'(a0);
    s_rd[1] = AW'(a1);
    s_rd[2] = AW'(a2);
    s_rd[3] = AW'(a3);
  endtask

  task automatic wr(input int k, input int a, input logic [DW-1:0] d, input logic ret);
    s_we[k]  = 1'b1;
    s_wa[k]  = AW'(a);
    s_wd[k]  = d;
    s_ret[k] = ret;
  endtask

  task automatic issue(input int a);
    s_iss = 1'b1;
    s_ia  = AW'(a);
  endtask

  // Apply one cycle: drive, predict outputs from pre-edge state, advance model.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    drive();
    cyc++;
    for (int i = 0; i < NR; i++) begin
      e.a_data[i*DW +: DW] = m_read(s_rd[i], 1'b1);
      e.b_data[i*DW +: DW] = m_read(s_rd[i], 1'b0);
      e.busy[i]            = (m_cnt[s_rd[i]] != 0);
    end
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);

    if (s_reset) begin
      model_clear();
    end else begin
      for (int k = 0; k < NW; k++)
        if (s_we[k] && s_wa[k] != '0) m_reg[s_wa[k]] = s_wd[k];
      for (int r = 1; r < NREG; r++) begin
        int n;
        n = m_cnt[r];
        if (s_iss && s_ia == AW'(r)) n = n + 1;
        for (int k = 0; k < NW; k++)
          if (s_we[k] && s_ret[k] && s_wa[k] == AW'(r)) n = n - 1;
        if (n > CMAX) begin
          n     = CMAX;
          m_ovf = 1'b1;
        end else if (n < 0) begin
          n     = 0;
          m_unf = 1'b1;
        end
        m_cnt[r] = n;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("rd_data_byp",   bus_a.rd_data, e.a_data);
        cmp("rd_data_nobyp", bus_b.rd_data, e.b_data);
        cmp("rd_busy_byp",   (NR*DW)'(bus_a.rd_busy), (NR*DW)'(e.busy));
        cmp("rd_busy_nobyp", (NR*DW)'(bus_b.rd_busy), (NR*DW)'(e.busy));
        cmp("ovf_err",       (NR*DW)'(bus_a.ovf_err), (NR*DW)'(e.ovf));
        cmp("unf_err",       (NR*DW)'(bus_a.unf_err), (NR*DW)'(e.unf));
      end
    end
  end

  initial begin
    int w;
    idle();
    set_rd(0, 0, 0, 0);
    s_reset = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    model_clear();
    step();                         // reset cycle, post-reset state visible
    idle();
    set_rd(0, 5, 5, 7);
    step();                         // reset state

    // r0 write dropped, r5 written; bypass shows it in the write cycle.
    wr(0, 0, 32'hFFFF_FFFF, 1'b0);
    wr(1, 5, 32'h1234_5678, 1'b0);
    step();
    idle();
    step();

    // Both ports hit r7: port 1 wins, including on the bypass path.
    set_rd(7, 7, 5, 0);
    wr(0, 7, 32'hAAAA_0000, 1'b0);
    wr(1, 7, 32'h0000_BBBB, 1'b0);
    step();
    idle();
    step();

    // Issue r3 three times, retire three times, then one extra retire.
    set_rd(3, 3, 9, 0);
    repeat (3) begin issue(3); step(); idle(); end
    repeat (4) begin wr(0, 3, 32'h0000_0033, 1'b1); step(); idle(); end
    step();
    // Retire on r0 and retire without write enable are ignored.
    s_ret[0] = 1'b1; s_wa[0] = AW'(4);
    wr(1, 0, 32'h1, 1'b1);
    issue(0);
    step();
    idle();

    // r9 counter saturates, then issue+retire nets out.
    repeat (4) begin issue(9); step(); idle(); end
    issue(9);
    wr(0, 9, 32'h99, 1'b1);
    step();
    idle();
    // Two ports retiring the same register decrement by two.
    wr(0, 9, 32'h91, 1'b1);
    wr(1, 9, 32'h92, 1'b1);
    step();
    idle();
    step();

    // Reset mid-sequence; a write during the reset cycle is lost.
    set_rd(10, 3, 9, 10);
    wr(0, 10, 32'h55, 1'b0);
    issue(10);
    step();
    idle();
    issue(11);
    step();
    idle();
    s_reset = 1'b1;
    wr(1, 10, 32'h77, 1'b0);
    step();
    idle();
    step();
    step();

    // All four ports read r12 while it is overwritten.
    set_rd(12, 12, 12, 12);
    wr(0, 12, 32'h0BAD_F00D, 1'b0);
    step();
    idle();
    step();
    wr(1, 12, 32'hDEAD_BEEF, 1'b0);
    step();
    idle();
    step();

    // Random traffic on a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      s_reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NR; i++) s_rd[i] = AW'($urandom_range(0, 15));
      for (int k = 0; k < NW; k++) begin
        s_we[k]  = ($urandom_range(0, 1) == 1);
        s_ret[k] = ($urandom_range(0, 2) == 0);
        s_wa[k]  = AW'($urandom_range(0, 15));
        s_wd[k]  = $urandom;
      end
      s_iss = ($urandom_range(0, 1) == 1);
      s_ia  = AW'($urandom_range(0, 15));
      step();
    end
    idle();
    step();

    w = 0;
    while (exp_q.size() != 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised general register file for the pipelined MIPS core. Generalises the fixed 32x32, 2-read/1-write GRF to configurable width, depth, read-port count and write-port count.
- Adds write-to-read bypass, so the decode stage sees same-cycle writeback data.
- Adds a per-register pending-write scoreboard (issue/retire counters), used by the hazard unit for stall decisions.
- Sits between the D stage (reads, issue) and the W stage (writeback, retire).

Parameters:
DW, 32, data width in bits
NREG, 32, number of registers (power of two, >=2)
AW, 5, address width, equals log2(NREG)
NR, 2, number of read ports (1..4)
NW, 1, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, is never busy
CW, 2, width of the per-register pending-write counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
rd_addr  in  NR*AW  read addresses; port i uses bits [i*AW +: AW]
rd_data  out  NR*DW  read data, combinational
rd_busy  out  NR  1 = the addressed register has a pending write
wr_en  in  NW  write enable per port
wr_addr  in  NW*AW  write addresses
wr_data  in  NW*DW  write data
wr_retire  in  NW  1 = this write also retires one pending issue (decrement)
issue_en  in  1  mark issue_addr as pending (increment)
issue_addr  in  AW  destination register being issued
ovf_err  out  1  sticky: an issue was attempted at counter max
unf_err  out  1  sticky: a retire was attempted at counter zero

Behaviour:
- Reset: synchronous, active-high, single cycle. On the clk edge with reset=1, all registers, all counters, ovf_err and unf_err are cleared to 0. All writes, issues and retires in that cycle are discarded.
- Immediately after reset: every rd_data reads 0 and every rd_busy reads 0.
- Write:
  - Performed at the rising edge when wr_en[k]=1.
  - If ZERO_REG=1 and wr_addr[k]=0, the write is dropped.
  - Two write ports targeting the same address in the same cycle: the higher-index port wins.
- Read is combinational from storage. If ZERO_REG=1 and the address is 0, the result is 0.
- Bypass (BYPASS=1): if any wr_en[k]=1 with wr_addr[k]==rd_addr[i] (and the address is not a hardwired zero), rd_data[i]=wr_data of the highest matching k.
  - With BYPASS=0, the new value becomes visible the cycle after the write.
- Counters: one CW-bit counter per register. Next value = cnt + inc - dec, where:
  - inc = issue_en for issue_addr.
  - dec = number of ports k with wr_en[k]&wr_retire[k] whose address matches. This counts per port, so two ports retiring the same register decrement by 2.
  - wr_retire[k] without wr_en[k] is ignored.
- Simultaneous issue and retire on the same register net out; the counter is unchanged and no error is flagged.
- Saturation:
  - If the result would exceed 2^CW-1, the counter holds at max and ovf_err is set.
  - If the result would go below 0, the counter clamps at 0 and unf_err is set.
  - Both flags stay set until reset.
- ZERO_REG=1: issues and retires to register 0 are ignored and flag nothing.
- rd_busy[i] = (registered counter at rd_addr[i]) != 0. It reflects the registered state only; a retire in the current cycle does not clear busy until the next cycle.
- No latency beyond one edge for any state update. Reads always have 0 cycles of latency.

Decomposition:
- Shared package (cpu_pkg): DW, AW and NREG defaults, plus the zero-register index constant (used by the ALU/hazard unit too).
- One natural sub-module: grf_sb_counter, a single saturating up/down counter with error pulse outputs. It is instantiated NREG times; the top ORs the pulses into the sticky flags.
- Storage, write-priority mux and bypass mux stay in the top level.

Test Plan:
- Reset, then write 0xFFFFFFFF to r0 and 0x12345678 to r5 -> r0 reads 0x0, r5 reads 0x12345678 on the next cycle; with BYPASS=1, rd_addr=5 shows 0x12345678 in the write cycle itself.
- NW=2: both ports write r7, port0=0xAAAA0000 and port1=0x0000BBBB -> r7=0x0000BBBB; the bypass read in the same cycle also returns 0x0000BBBB.
- Issue r3 three times -> rd_busy=1 for r3. Retire r3 three times -> busy clears on the cycle after the third retire. A fourth retire sets unf_err=1 and the counter stays 0.
- CW=2: issue r9 four times -> counter holds at 3 and ovf_err=1. Issue and retire r9 in the same cycle -> counter stays 3 and no new error.
- Write r10=0x55 with issue pending, then assert reset mid-sequence -> the next cycle shows r10 reads 0, all rd_busy=0 and ovf_err=unf_err=0. A write asserted during the reset cycle is lost.
- BYPASS=0 with NR=4, all ports reading r12 while it is written with 0xDEADBEEF -> old value in the write cycle, 0xDEADBEEF on all four ports in the next cycle.
